// File: rtl/shift_reg_univ.sv
// shift_reg_univ: WIDTH-bit universal register with a saturating shift counter.
//   Modes: hold, load, shift left/right, rotate left/right, arithmetic shift
//   right, clear. The counter tracks shifts since the last load/clear and
//   saturates at WIDTH, so the block can act as a serializer/deserializer.
// Optional feature macro: SHIFT_REG_PARITY_EN adds registered output par = ^q.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-low reset
//   en      - clock enable; 0 holds all state
//   mode    - operation select
//   d       - parallel load data
//   sin_l   - serial in at MSB (SHR)
//   sin_r   - serial in at LSB (SHL)
//   q       - registered contents
//   sout_l  - q[WIDTH-1]
//   sout_r  - q[0]
//   cnt     - shifts since last load/clear, saturating at WIDTH
//   done    - cnt == WIDTH
//   par     - (SHIFT_REG_PARITY_EN only) XOR reduction of q, registered
module shift_reg_univ #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             done
`ifdef SHIFT_REG_PARITY_EN
  ,
  output logic             par
`endif
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             shift_en;

  // Next-state decode; unknown mode codes fall to hold so cnt is never corrupted.
  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], sin_r};
          shift_en = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {sin_l, q_q[WIDTH-1:1]};
          shift_en = 1'b1;
        end
        MODE_ROL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          shift_en = 1'b1;
        end
        MODE_ROR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          shift_en = 1'b1;
        end
        MODE_ASR: begin
          q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          shift_en = 1'b1;
        end
        MODE_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // Counter saturates at WIDTH; shifting itself continues past done.
    if (shift_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef SHIFT_REG_PARITY_EN
  logic par_q, par_d;

  // Parity taken from the next-state value so it tracks q with no extra latency.
  always_comb begin
    par_d = ^q_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      par_q <= ^RESET_VAL;
    end else begin
      par_q <= par_d;
    end
  end

  assign par = par_q;
`endif

  assign q      = q_q;
  assign cnt    = cnt_q;
  assign done   = (cnt_q == CNT_MAX);
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

endmodule
